// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the CPU request/response channel and the RAM bus that
// surround mem_ctrl.
//   CPU side : req_valid/req_ready handshake, req_we, req_addr[9:0],
//              req_size[1:0], req_signed, req_wdata[31:0];
//              resp_valid pulse, resp_rdata[31:0], resp_err.
//   RAM side : ram_addr[7:0] (word address), ram_cs, ram_rd, ram_oe,
//              ram_wdata[31:0], ram_rdata[31:0] (combinational from RAM).
// Modports: slave = the controller, master = the CPU plus RAM environment.
interface mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  ram_addr;
  logic        ram_cs;
  logic        ram_rd;
  logic        ram_oe;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           ram_addr, ram_cs, ram_rd, ram_oe, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           ram_addr, ram_cs, ram_rd, ram_oe, ram_wdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte/halfword/word load-store controller in front of a 256 x 32
// single-port RAM. Sub-word stores are performed as read-modify-write.
// Ports:
//   clk        single clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   bus        mem_ctrl_if.slave (CPU request/response + RAM bus)
// Parameter:
//   BIG_ENDIAN 0 = byte 0 in bits [7:0], 1 = byte 0 in bits [31:24]
// Configuration macro:
//   MEM_CTRL_ALIGN_CHECK_EN  defined   : misaligned half/word accesses
//                                        complete with resp_err and no RAM access
//                            undefined : misaligned low address bits are
//                                        cleared and the access proceeds
//   A reserved size (3) is always an error.
module mem_ctrl #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input logic clk,
  input logic rst_n,
  mem_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0]  state_r;
  logic [1:0]  next_state_s;
  logic        we_r;
  logic [9:0]  addr_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic [31:0] wdata_r;
  logic [31:0] word_r;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;

  logic        accept_s;
  logic        acc_err_s;
  logic [9:0]  acc_addr_s;
  logic [31:0] resp_rdata_s;
  logic        resp_err_s;

  // Pick the addressed byte/half out of a RAM word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  a,
                                               input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic        be);
    logic [1:0]  lane;
    logic        lane_h;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    lane   = be ? (2'd3 - a) : a;
    lane_h = be ? ~a[1] : a[1];
    b      = word[{lane, 3'b000} +: 8];
    h      = word[{lane_h, 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replace only the addressed lanes of the captured word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  a,
                                              input logic [1:0]  size,
                                              input logic        be);
    logic [1:0]  lane;
    logic        lane_h;
    logic [31:0] r;
    lane   = be ? (2'd3 - a) : a;
    lane_h = be ? ~a[1] : a[1];
    r      = word;
    case (size)
      SZ_BYTE: r[{lane, 3'b000} +: 8]    = wd[7:0];
      SZ_HALF: r[{lane_h, 4'b0000} +: 16] = wd[15:0];
      SZ_WORD: r = wd;
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept_s = bus.req_valid && (state_r == IDLE);

  // Classify the incoming request: error detection and effective address.
  always_comb begin
    acc_err_s  = (bus.req_size == 2'd3);
    acc_addr_s = bus.req_addr;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    if ((bus.req_size == SZ_HALF) && bus.req_addr[0]) begin
      acc_err_s = 1'b1;
    end else if ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00)) begin
      acc_err_s = 1'b1;
    end else begin
      acc_err_s = (bus.req_size == 2'd3);
    end
`else
    if (bus.req_size == SZ_HALF) begin
      acc_addr_s[0] = 1'b0;
    end else if (bus.req_size == SZ_WORD) begin
      acc_addr_s[1:0] = 2'b00;
    end else begin
      acc_addr_s = bus.req_addr;
    end
`endif
  end

  // Next-state logic; sub-word stores read first so untouched lanes survive.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          next_state_s = IDLE;
        end else if (acc_err_s) begin
          next_state_s = RESP;
        end else if (!bus.req_we) begin
          next_state_s = READ;
        end else if (bus.req_size == SZ_WORD) begin
          next_state_s = WRITE;
        end else begin
          next_state_s = READ;
        end
      end
      READ:    next_state_s = we_r ? WRITE : RESP;
      WRITE:   next_state_s = RESP;
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Response payload, registered so it is valid exactly during RESP.
  always_comb begin
    resp_rdata_s = 32'h0000_0000;
    resp_err_s   = 1'b0;
    if (accept_s && acc_err_s) begin
      resp_err_s = 1'b1;
    end else if ((state_r == READ) && !we_r) begin
      resp_rdata_s = load_extract(bus.ram_rdata, addr_r[1:0], size_r, signed_r, BIG_ENDIAN);
    end else begin
      resp_rdata_s = 32'h0000_0000;
      resp_err_s   = 1'b0;
    end
  end

  // State, latched request fields, captured RAM word and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      addr_r       <= 10'd0;
      size_r       <= 2'd0;
      signed_r     <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      word_r       <= 32'h0000_0000;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      resp_rdata_r <= resp_rdata_s;
      resp_err_r   <= resp_err_s;
      if (accept_s) begin
        we_r     <= bus.req_we;
        addr_r   <= acc_addr_s;
        size_r   <= bus.req_size;
        signed_r <= bus.req_signed;
        wdata_r  <= bus.req_wdata;
      end
      if (state_r == READ) begin
        word_r <= bus.ram_rdata;
      end
    end
  end

  // RAM strobes decoded from registered state only, so reset drops ram_cs at once.
  always_comb begin
    bus.ram_cs    = 1'b0;
    bus.ram_rd    = 1'b1;
    bus.ram_oe    = 1'b0;
    bus.ram_wdata = 32'h0000_0000;
    case (state_r)
      READ: begin
        bus.ram_cs = 1'b1;
        bus.ram_rd = 1'b1;
        bus.ram_oe = 1'b1;
      end
      WRITE: begin
        bus.ram_cs    = 1'b1;
        bus.ram_rd    = 1'b0;
        bus.ram_oe    = 1'b0;
        bus.ram_wdata = store_merge(word_r, wdata_r, addr_r[1:0], size_r, BIG_ENDIAN);
      end
      default: begin
        bus.ram_cs    = 1'b0;
        bus.ram_rd    = 1'b1;
        bus.ram_oe    = 1'b0;
        bus.ram_wdata = 32'h0000_0000;
      end
    endcase
  end

  assign bus.ram_addr   = addr_r[9:2];
  assign bus.req_ready  = (state_r == IDLE);
  assign bus.resp_valid = (state_r == RESP);
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: drives a little-endian and a big-endian mem_ctrl with the same
// request stream; each has its own behavioural RAM. A byte-addressed model
// predicts responses, latencies, RAM strobes and memory contents.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if if_le();
  mem_ctrl_if if_be();

  mem_ctrl #(.BIG_ENDIAN(1'b0)) u_le (.clk(clk), .rst_n(rst_n), .bus(if_le));
  mem_ctrl #(.BIG_ENDIAN(1'b1)) u_be (.clk(clk), .rst_n(rst_n), .bus(if_be));

  logic [31:0] ram       [2][256];
  logic [31:0] model_mem [2][256];

  // RAM behaviour: combinational read, write on negedge.
  assign if_le.ram_rdata = (if_le.ram_cs && if_le.ram_rd && if_le.ram_oe) ? ram[0][if_le.ram_addr] : 32'h0;
  assign if_be.ram_rdata = (if_be.ram_cs && if_be.ram_rd && if_be.ram_oe) ? ram[1][if_be.ram_addr] : 32'h0;
  always @(negedge clk) begin
    if (if_le.ram_cs && !if_le.ram_rd) ram[0][if_le.ram_addr] = if_le.ram_wdata;
    if (if_be.ram_cs && !if_be.ram_rd) ram[1][if_be.ram_addr] = if_be.ram_wdata;
  end

  logic        rv[2], rdy[2], er[2], cs[2], rd[2], oe[2];
  logic [31:0] rdat[2], wdat[2];
  logic [7:0]  ra[2];
  assign rv[0] = if_le.resp_valid;  assign rv[1] = if_be.resp_valid;
  assign rdy[0] = if_le.req_ready;  assign rdy[1] = if_be.req_ready;
  assign er[0] = if_le.resp_err;    assign er[1] = if_be.resp_err;
  assign cs[0] = if_le.ram_cs;      assign cs[1] = if_be.ram_cs;
  assign rd[0] = if_le.ram_rd;      assign rd[1] = if_be.ram_rd;
  assign oe[0] = if_le.ram_oe;      assign oe[1] = if_be.ram_oe;
  assign rdat[0] = if_le.resp_rdata; assign rdat[1] = if_be.resp_rdata;
  assign wdat[0] = if_le.ram_wdata;  assign wdat[1] = if_be.ram_wdata;
  assign ra[0] = if_le.ram_addr;     assign ra[1] = if_be.ram_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected transaction in flight
  bit          pending = 1'b0;
  int          acc_cyc = 0;
  int          lat = 0;
  bit          exp_no_ram = 1'b0;
  bit          exp_we = 1'b0;
  logic        exp_err = 1'b0;
  logic [7:0]  exp_waddr = 8'd0;
  logic [31:0] exp_rdata[2];
  logic [31:0] exp_new[2];
  // Observations
  logic [31:0] last_rdata[2];
  logic        last_err[2];
  bit          obs_cs[2];
  logic [7:0]  obs_addr[2];
  int          resp_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: actual %h required %h", name, $time, act, exp);
    end
  endtask

  // Memory byte k of a word sits at bit lane k (LE) or 3-k (BE).
  function automatic logic [7:0] get_b(input bit be, input logic [31:0] w, input int k);
    int p;
    p = be ? 3 - k : k;
    return w[8*p +: 8];
  endfunction

  function automatic logic [31:0] put_b(input bit be, input logic [31:0] w, input int k, input logic [7:0] v);
    int p;
    logic [31:0] r;
    p = be ? 3 - k : k;
    r = w;
    r[8*p +: 8] = v;
    return r;
  endfunction

  // Predict the outcome of one accepted request from byte-level rules.
  function automatic void model_accept(input logic we, input logic [9:0] addr,
                                       input logic [1:0] size, input logic sgn,
                                       input logic [31:0] wd);
    int n, off, sig;
    bit err;
    logic [31:0] w, v, m;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    err = (n == 0);
    off = int'(addr[1:0]);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    if (n > 0 && (off % n) != 0) err = 1'b1;
`else
    if (n > 0) off = off - (off % n);
`endif
    exp_err    = err;
    exp_no_ram = err;
    exp_we     = we && !err;
    exp_waddr  = addr[9:2];
    lat        = err ? 1 : (!we ? 2 : (n == 4 ? 2 : 3));
    for (int i = 0; i < 2; i++) begin
      w = model_mem[i][addr[9:2]];
      exp_rdata[i] = 32'h0;
      exp_new[i]   = w;
      if (!err && we) begin
        for (int j = 0; j < n; j++) begin
          sig = (i == 1) ? n - 1 - j : j;
          w = put_b(i == 1, w, off + j, wd[8*sig +: 8]);
        end
        exp_new[i] = w;
      end else if (!err) begin
        v = 32'h0;
        for (int j = 0; j < n; j++) begin
          sig = (i == 1) ? n - 1 - j : j;
          v = v | ({24'h0, get_b(i == 1, w, off + j)} << (8*sig));
        end
        if (n < 4 && sgn && v[8*n-1]) begin
          m = (32'h1 << (8*n)) - 32'h1;
          v = v | ~m;
        end
        exp_rdata[i] = v;
      end
    end
  endfunction

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    int d;
    logic erv;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("rst_req_ready", rdy[i], 1);
        chk("rst_resp_valid", rv[i], 0);
        chk("rst_resp_err", er[i], 0);
        chk("rst_resp_rdata", rdat[i], 0);
        chk("rst_ram_cs", cs[i], 0);
        chk("rst_ram_rd", rd[i], 1);
        chk("rst_ram_oe", oe[i], 0);
        chk("rst_ram_addr", ra[i], 0);
        chk("rst_ram_wdata", wdat[i], 0);
      end
    end else begin
      d = cyc - acc_cyc;
      for (int i = 0; i < 2; i++) begin
        erv = pending && (d == lat - 1);
        chk("resp_valid", rv[i], erv);
        if (erv) begin
          chk("resp_rdata", rdat[i], exp_rdata[i]);
          chk("resp_err", er[i], exp_err);
          last_rdata[i] = rdat[i];
          last_err[i]   = er[i];
          if (exp_we) model_mem[i][exp_waddr] = exp_new[i];
          chk("ram_word", ram[i][exp_waddr], model_mem[i][exp_waddr]);
        end
        chk("req_ready", rdy[i], !(pending && d < lat));
        chk("ram_cs", cs[i], pending && !exp_no_ram && d < lat - 1);
        if (cs[i]) begin
          chk("ram_addr", ra[i], exp_waddr);
          obs_cs[i]   = 1'b1;
          obs_addr[i] = ra[i];
        end
      end
      if (rv[0]) resp_count++;
      if (pending && d >= lat) pending = 1'b0;
    end
  end

  task automatic drive(input logic v, input logic we, input logic [9:0] a,
                       input logic [1:0] s, input logic sg, input logic [31:0] wd);
    if_le.req_valid = v; if_le.req_we = we; if_le.req_addr = a;
    if_le.req_size = s;  if_le.req_signed = sg; if_le.req_wdata = wd;
    if_be.req_valid = v; if_be.req_we = we; if_be.req_addr = a;
    if_be.req_size = s;  if_be.req_signed = sg; if_be.req_wdata = wd;
  endtask

  task automatic start_req(input logic we, input logic [9:0] a, input logic [1:0] s,
                           input logic sg, input logic [31:0] wd);
    @(negedge clk); #1;
    model_accept(we, a, s, sg, wd);
    obs_cs[0] = 1'b0; obs_cs[1] = 1'b0;
    acc_cyc = cyc + 1;
    pending = 1'b1;
    drive(1'b1, we, a, s, sg, wd);
    @(posedge clk); #1;
    // Junk on the inputs while busy must not disturb the operation in flight.
    drive(1'($urandom), 1'($urandom), 10'($urandom), 2'($urandom), 1'($urandom), $urandom);
  endtask

  task automatic issue(input logic we, input logic [9:0] a, input logic [1:0] s,
                       input logic sg, input logic [31:0] wd);
    start_req(we, a, s, sg, wd);
    for (int k = 0; k < 20 && pending; k++) begin
      @(negedge clk); #1;
      if (!pending || (cyc - acc_cyc >= lat - 1))
        drive(1'b0, 1'($urandom), 10'($urandom), 2'($urandom), 1'($urandom), $urandom);
      else
        drive(1'($urandom), 1'($urandom), 10'($urandom), 2'($urandom), 1'($urandom), $urandom);
    end
    chk("resp_timeout", pending, 0);
    pending = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_cs;
    int          snap;
    drive(1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 32'h0);
    for (int k = 0; k < 256; k++) begin
      w = $urandom;
      ram[0][k] = w; ram[1][k] = w;
      model_mem[0][k] = w; model_mem[1][k] = w;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Word store then word load
    issue(1'b1, 10'h010, 2'd2, 1'b0, 32'hDEADBEEF);
    issue(1'b0, 10'h010, 2'd2, 1'b0, 32'h0);
    chk("t033_ram_addr", obs_addr[0], 8'h04);
    chk("t033_rdata_le", last_rdata[0], 32'hDEADBEEF);
    chk("t033_rdata_be", last_rdata[1], 32'hDEADBEEF);
    chk("t033_err", last_err[0], 1'b0);

    // Byte store over 0x11223344, then signed byte load
    issue(1'b1, 10'h010, 2'd2, 1'b0, 32'h11223344);
    issue(1'b1, 10'h013, 2'd0, 1'b0, 32'h000000AA);
    chk("t034_word_le", ram[0][4], 32'hAA223344);
    chk("t034_word_be", ram[1][4], 32'h112233AA);
    issue(1'b0, 10'h013, 2'd0, 1'b1, 32'h0);
    chk("t034_rdata_le", last_rdata[0], 32'hFFFFFFAA);
    chk("t034_rdata_be", last_rdata[1], 32'hFFFFFFAA);

    // Unsigned halfword load at 0x012 from 0x80017FFE
    issue(1'b1, 10'h010, 2'd2, 1'b0, 32'h80017FFE);
    issue(1'b0, 10'h012, 2'd1, 1'b0, 32'h0);
    chk("t035_rdata_be", last_rdata[1], 32'h00007FFE);
    chk("t035_rdata_le", last_rdata[0], 32'h00008001);

    // Misaligned word load at 0x011
    issue(1'b0, 10'h011, 2'd2, 1'b0, 32'h0);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    e_err = 1'b1; e_cs = 1'b0; e_rdata = 32'h0;
`else
    e_err = 1'b0; e_cs = 1'b1; e_rdata = 32'h80017FFE;
`endif
    chk("t036_err", last_err[0], e_err);
    chk("t036_cs_seen", obs_cs[0], e_cs);
    chk("t036_rdata", last_rdata[0], e_rdata);

    // Reset pulsed during the WRITE of a byte store
    snap = resp_count;
    start_req(1'b1, 10'h010, 2'd0, 1'b0, 32'h00000055);
    drive(1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    pending = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("t037_ready_le", rdy[0], 1'b1);
    chk("t037_ready_be", rdy[1], 1'b1);
    chk("t037_word_le", ram[0][4], 32'h80017FFE);
    chk("t037_word_be", ram[1][4], 32'h80017FFE);
    chk("t037_no_resp", resp_count, snap);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom), 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)),
            1'($urandom), $urandom);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
